// File: rtl/run_sequencer_if.sv
// Run-control bundle between the bench/core side and the run sequencer.
// The sequencer takes the master view: it drives the core controls and status.
interface run_sequencer_if #(
  parameter int PW = 10,
  parameter int CW = 16
);
  logic          Req;
  logic [1:0]    ProgSel;
  logic          HaltIn;
  logic          CoreReset;
  logic          CoreEn;
  logic [PW-1:0] PCInit;
  logic          Busy;
  logic          Done;
  logic          Timeout;
  logic [CW-1:0] CycleCount;

  modport master (
    input  Req, ProgSel, HaltIn,
    output CoreReset, CoreEn, PCInit, Busy, Done, Timeout, CycleCount
  );

  modport slave (
    output Req, ProgSel, HaltIn,
    input  CoreReset, CoreEn, PCInit, Busy, Done, Timeout, CycleCount
  );
endinterface

// File: rtl/run_sequencer.sv
// Run-level controller: starts a program on a rising Req, holds the core in
// reset for one load cycle, then runs it until halt or the watchdog fires.
module run_sequencer #(
  parameter int            PW         = 10,
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF,
  parameter logic [PW-1:0] START0     = '0,
  parameter logic [PW-1:0] START1     = '0,
  parameter logic [PW-1:0] START2     = '0,
  parameter logic [PW-1:0] START3     = '0
) (
  input logic            Clk,
  input logic            Reset,
  run_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic          req_q;
  logic          start;
  logic          accept;
  logic          watchdog_hit;
  logic          timeout_set;
  logic [1:0]    run_sel;
  logic [1:0]    run_sel_next;
  logic [CW-1:0] count_inc;

  logic          core_reset_r;
  logic [PW-1:0] pc_init_r;
  logic          busy_r;
  logic          done_r;
  logic          timeout_r;
  logic [CW-1:0] cycle_count_r;

  // Entry address table indexed by program select.
  function automatic logic [PW-1:0] start_addr(input logic [1:0] sel);
    logic [PW-1:0] addr;
    case (sel)
      2'd0:    addr = START0;
      2'd1:    addr = START1;
      2'd2:    addr = START2;
      default: addr = START3;
    endcase
    return addr;
  endfunction

  assign start        = bus.Req & ~req_q;
  assign accept       = start && (state == IDLE || state == DONE);
  assign count_inc    = cycle_count_r + {{(CW-1){1'b0}}, 1'b1};
  // The watchdog compares against the post-increment count so that exactly
  // MAX_CYCLES RUN cycles execute before the forced stop.
  assign watchdog_hit = (count_inc == MAX_CYCLES);
  assign timeout_set  = (state == RUN) && !bus.HaltIn && watchdog_hit;

  // State register; reset returns to IDLE from anywhere, including mid-run.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic plus the one combinational output, CoreEn.
  always_comb begin
    next_state   = state;
    run_sel_next = run_sel;
    bus.CoreEn   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          next_state   = LOAD;
          run_sel_next = bus.ProgSel;
        end
      end
      LOAD: next_state = RUN;
      RUN: begin
        // The halt instruction itself commits nothing, freezing the PC on it.
        bus.CoreEn = ~bus.HaltIn;
        if (bus.HaltIn || watchdog_hit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with
  // the state they describe, plus start-edge tracking and the run counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q         <= 1'b0;
      run_sel       <= 2'd0;
      core_reset_r  <= 1'b1;
      pc_init_r     <= START0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      cycle_count_r <= '0;
    end else begin
      req_q         <= bus.Req;
      run_sel       <= run_sel_next;
      pc_init_r     <= start_addr(run_sel_next);
      core_reset_r  <= (next_state == IDLE) || (next_state == LOAD);
      busy_r        <= (next_state == LOAD) || (next_state == RUN);
      done_r        <= (next_state == DONE);
      if (accept) begin
        cycle_count_r <= '0;
        timeout_r     <= 1'b0;
      end else if (state == RUN) begin
        cycle_count_r <= count_inc;
        if (timeout_set) timeout_r <= 1'b1;
      end
    end
  end

  assign bus.CoreReset  = core_reset_r;
  assign bus.PCInit     = pc_init_r;
  assign bus.Busy       = busy_r;
  assign bus.Done       = done_r;
  assign bus.Timeout    = timeout_r;
  assign bus.CycleCount = cycle_count_r;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios with literal expectations, then
// randomized Req/HaltIn/ProgSel/Reset traffic, all compared every cycle against
// a run-history model (edges since start, finished flag, run length).
module tb_run_sequencer;
  localparam int PW   = 10;
  localparam int CW   = 16;
  localparam int MAXC = 8;
  localparam logic [PW-1:0] S0 = 10'd5;
  localparam logic [PW-1:0] S1 = 10'd40;
  localparam logic [PW-1:0] S2 = 10'd100;
  localparam logic [PW-1:0] S3 = 10'd700;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  run_sequencer_if #(.PW(PW), .CW(CW)) bus ();

  run_sequencer #(
    .PW(PW), .CW(CW), .MAX_CYCLES(16'(MAXC)),
    .START0(S0), .START1(S1), .START2(S2), .START3(S3)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] addr_of(input logic [1:0] sel);
    logic [PW-1:0] a;
    case (sel)
      2'd0: a = S0;
      2'd1: a = S1;
      2'd2: a = S2;
      default: a = S3;
    endcase
    return a;
  endfunction

  // Model: a run is described by how many edges have passed since its start
  // edge (0 = load cycle, k = k-th run cycle) and whether it has finished.
  bit            m_valid, m_active, m_finished, m_to, m_req_q;
  int            m_since, m_len;
  logic [PW-1:0] m_pc;

  task automatic model_step();
    bit st;
    if (rst) begin
      m_valid = 1; m_active = 0; m_finished = 0; m_to = 0; m_req_q = 0;
      m_since = 0; m_len = 0; m_pc = S0;
    end else if (m_valid) begin
      st = bus.Req && !m_req_q;
      m_req_q = bus.Req;
      if (m_active && !m_finished) begin
        if (m_since >= 1 && (bus.HaltIn || m_since == MAXC)) begin
          m_finished = 1;
          m_len = m_since;
          m_to = !bus.HaltIn;
        end else begin
          m_since++;
        end
      end else if (st) begin
        m_active = 1; m_finished = 0; m_since = 0; m_to = 0;
        m_pc = addr_of(bus.ProgSel);
      end
    end
  endtask

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    int exp_count;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        if (m_finished)                    exp_count = m_len;
        else if (m_active && m_since > 0)  exp_count = m_since - 1;
        else                               exp_count = 0;
        check("m_busy", 32'(bus.Busy), 32'(m_active && !m_finished));
        check("m_core_reset", 32'(bus.CoreReset), 32'(!m_active || (!m_finished && m_since == 0)));
        check("m_core_en", 32'(bus.CoreEn), 32'(m_active && !m_finished && m_since >= 1 && !bus.HaltIn));
        check("m_done", 32'(bus.Done), 32'(m_finished));
        check("m_timeout", 32'(bus.Timeout), 32'(m_finished && m_to));
        check("m_count", 32'(bus.CycleCount), 32'(exp_count));
        check("m_pc_init", 32'(bus.PCInit), 32'(m_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a rising Req; on return the sequencer is in its load cycle.
  task automatic start_run(input logic [1:0] sel);
    bus.ProgSel = sel;
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.Req = 1'b0;
    bus.HaltIn = 1'b0;
    bus.ProgSel = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_core_reset", 32'(bus.CoreReset), 32'd1);
    check("rst_core_en", 32'(bus.CoreEn), 32'd0);
    check("rst_pc_init", 32'(bus.PCInit), 32'd5);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_count", 32'(bus.CycleCount), 32'd0);

    // Basic run: halt on the 5th run cycle.
    start_run(2'd1);
    @(negedge clk);
    check("basic_load_pc", 32'(bus.PCInit), 32'd40);
    check("basic_load_busy", 32'(bus.Busy), 32'd1);
    check("basic_load_core_reset", 32'(bus.CoreReset), 32'd1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("basic_core_en", 32'(bus.CoreEn), 32'd1);
      tick();
    end
    bus.HaltIn = 1'b1;
    @(negedge clk);
    check("basic_halt_core_en", 32'(bus.CoreEn), 32'd0);
    tick();
    bus.HaltIn = 1'b0;
    @(negedge clk);
    check("basic_done", 32'(bus.Done), 32'd1);
    check("basic_count", 32'(bus.CycleCount), 32'd5);
    check("basic_timeout", 32'(bus.Timeout), 32'd0);
    check("basic_core_reset", 32'(bus.CoreReset), 32'd0);

    // Watchdog: no halt, exactly MAXC run cycles.
    start_run(2'd0);
    tick();
    repeat (MAXC - 1) tick();
    @(negedge clk);
    check("wd_last_busy", 32'(bus.Busy), 32'd1);
    tick();
    @(negedge clk);
    check("wd_done", 32'(bus.Done), 32'd1);
    check("wd_timeout", 32'(bus.Timeout), 32'd1);
    check("wd_count", 32'(bus.CycleCount), 32'd8);

    // Back-to-back with halt on the watchdog cycle: halt wins.
    start_run(2'd2);
    @(negedge clk);
    check("b2b_load_pc", 32'(bus.PCInit), 32'd100);
    check("b2b_timeout_cleared", 32'(bus.Timeout), 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("b2b_count_restart", 32'(bus.CycleCount), 32'd1);
    repeat (MAXC - 2) tick();
    bus.HaltIn = 1'b1;
    tick();
    bus.HaltIn = 1'b0;
    @(negedge clk);
    check("b2b_halt_timeout", 32'(bus.Timeout), 32'd0);
    check("b2b_halt_count", 32'(bus.CycleCount), 32'd8);

    // Requests during a run are ignored.
    start_run(2'd3);
    tick();
    bus.Req = 1'b1; tick();
    bus.Req = 1'b0; tick();
    bus.Req = 1'b1; tick();
    tick();
    bus.HaltIn = 1'b1;
    tick();
    bus.HaltIn = 1'b0;
    @(negedge clk);
    check("ign_count", 32'(bus.CycleCount), 32'd5);
    repeat (3) tick();
    @(negedge clk);
    check("held_req_done", 32'(bus.Done), 32'd1);
    check("held_req_busy", 32'(bus.Busy), 32'd0);
    bus.Req = 1'b0; tick();
    bus.Req = 1'b1; tick();
    @(negedge clk);
    check("rereq_busy", 32'(bus.Busy), 32'd1);
    check("rereq_pc", 32'(bus.PCInit), 32'd700);

    // Reset in run cycle 3 with Req still high.
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_core_reset", 32'(bus.CoreReset), 32'd1);
    check("midrst_core_en", 32'(bus.CoreEn), 32'd0);
    check("midrst_count", 32'(bus.CycleCount), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("postrst_load_busy", 32'(bus.Busy), 32'd1);
    bus.Req = 1'b0;
    tick();
    bus.HaltIn = 1'b1;
    tick();
    bus.HaltIn = 1'b0;
    @(negedge clk);
    check("postrst_count", 32'(bus.CycleCount), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) bus.Req = ~bus.Req;
      bus.HaltIn = ($urandom_range(0, 5) == 0);
      bus.ProgSel = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run-level controller sitting between the test bench and the processor core (PC, reg_file, data_mem, Ctrl decoder). It accepts a start request, selects one of four program entry addresses, holds the core in reset for one load cycle, then enables execution until the decoder flags the halt instruction (all-ones opcode) or a watchdog expires. It reports completion, timeout and the executed cycle count.

## Interface
- PW, 10, PC / start-address width
- CW, 16, cycle-counter width
- MAX_CYCLES, 16'hFFFF, watchdog limit in RUN cycles (>=2)
- START0..START3, 0 / 0 / 0 / 0, entry address per program select (PW bits each)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- Req  in  1  start request from bench; start is a rising edge of Req
- ProgSel  in  2  program select, sampled with the start edge
- HaltIn  in  1  halt decoded this cycle (Ctrl's Ack)
- CoreReset  out  1  holds PC at PCInit, clears core state
- CoreEn  out  1  commit enable for PC, reg_file writes, mem writes
- PCInit  out  PW  PC load address
- Busy  out  1  run in progress (LOAD or RUN)
- Done  out  1  run finished
- Timeout  out  1  last run ended by watchdog
- CycleCount  out  CW  RUN cycles of current/last run

## Operation
- ReqQ: registered Req, reset 0. Start = Req & ~ReqQ.
- States: IDLE, LOAD, RUN, DONE. Reset → IDLE from any state, highest priority, including mid-run.
- IDLE: CoreReset=1, CoreEn=0, Busy=0, Done=0. Start → LOAD; latch ProgSel into RunSel.
- LOAD (exactly 1 cycle): CoreReset=1, Busy=1, CycleCount←0, Timeout←0 → RUN.
- RUN: CoreReset=0, Busy=1. CycleCount increments every RUN cycle, including the halt cycle.
  - CoreEn = ~HaltIn. The halt instruction commits nothing and the PC freezes on it.
- RUN exit on HaltIn=1 → DONE, Timeout stays 0.
- RUN exit on watchdog: when HaltIn=0 and CycleCount+1 == MAX_CYCLES, go → DONE and set Timeout←1.
- Halt and watchdog in the same cycle: halt wins, Timeout=0.
- DONE: Done=1, Busy=0, CoreEn=0, CoreReset=0 so core state is preserved for bench inspection. CycleCount and Timeout are held. Start → LOAD (new run, new ProgSel).
- Start while in LOAD or RUN is ignored; ReqQ still tracks Req.
- PCInit = START[RunSel], registered. RunSel resets to 0.
- CycleCount never wraps: the watchdog terminates the run first, since MAX_CYCLES ≤ 2^CW−1.
- Reset values: CoreReset=1, CoreEn=0, PCInit=START0, Busy=0, Done=0, Timeout=0, CycleCount=0, state IDLE, ReqQ=0.

## Timing
- Req=1 with ReqQ=0 sampled at edge n:
  - LOAD occupies cycle n..n+1 with PCInit valid.
  - First RUN cycle starts at edge n+1; PC fetches PCInit in that cycle.
- Start-to-first-instruction latency: 2 edges.
- HaltIn high in RUN cycle k: DONE from edge k+1; Done=1 and final CycleCount visible from edge k+1.
- CoreEn is combinational from state and HaltIn. All other outputs are registered.
- Req held high through Reset deassertion: ReqQ=0 after reset, so a start is taken at the first post-reset edge.
- Reset asserted during RUN: next edge is IDLE with CoreReset=1, and Done is not asserted.

## Test plan
- Basic run: START1=10'd40, ProgSel=1, pulse Req, HaltIn high on the 5th RUN cycle → PCInit=40 during LOAD; CoreEn=1 for 4 cycles, then 0 on the halt cycle; Done=1, CycleCount=5, Timeout=0.
- Watchdog: MAX_CYCLES=8, HaltIn never asserted → exactly 8 RUN cycles, then Done=1, Timeout=1, CycleCount=8. Repeat with HaltIn on the 8th cycle → Timeout=0, CycleCount=8.
- Back-to-back: after Done, drop Req and raise it with ProgSel=2 (START2=100) → LOAD with PCInit=100; CycleCount restarts at 1 on the first RUN cycle; Timeout cleared.
- Ignored request: toggle Req 0→1→0→1 during RUN → no re-LOAD, CycleCount is monotonic, the run ends only on HaltIn.
- Reset mid-run: assert Reset in RUN cycle 3 → next cycle IDLE, CoreReset=1, CoreEn=0, Busy=0, CycleCount=0, Done=0.
- Req high across reset release → LOAD on the first post-reset edge. Req held high after Done → no new run until Req falls and rises again.
